// File: rtl/zip_slave_router_if.sv
// Bus bundle between one master's decoder output, the routing stage and the slaves.
// The slave modport is the router's view; the master modport is the surrounding environment.
interface zip_slave_router_if #(
    parameter int NS  = 8,
    parameter int AW  = 32,
    parameter int DW  = 37,
    parameter int RDW = 32
);
    // master-facing request and return
    logic              cyc;
    logic              valid;
    logic              stall;
    logic [NS:0]       decode;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic              ack;
    logic              err;
    logic [RDW-1:0]    rdata;
    logic              timeout;

    // slave-facing request and return
    logic [NS-1:0]     svalid;
    logic [NS-1:0]     sstall;
    logic [AW-1:0]     saddr;
    logic [DW-1:0]     sdata;
    logic [NS-1:0]     sack;
    logic [NS-1:0]     serr;
    logic [NS*RDW-1:0] srdata;

    modport master (
        output cyc, valid, decode, addr, data, sstall, sack, serr, srdata,
        input  stall, svalid, saddr, sdata, ack, err, rdata, timeout
    );

    modport slave (
        input  cyc, valid, decode, addr, data, sstall, sack, serr, srdata,
        output stall, svalid, saddr, sdata, ack, err, rdata, timeout
    );
endinterface

// File: rtl/zip_slave_router.sv
// Per-master routing stage: forwards decoded requests to one slave, pins the grant while
// responses are outstanding and returns registered ack/err/rdata from the granted slave only.
module zip_slave_router #(
    parameter int NS          = 8,
    parameter int AW          = 32,
    parameter int DW          = 37,
    parameter int RDW         = 32,
    parameter int LGMAXBURST  = 4,
    parameter int OPT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    zip_slave_router_if.slave bus
);
    localparam int            CW         = LGMAXBURST;
    localparam logic [CW-1:0] COUNT_MAX  = {CW{1'b1}};
    localparam int            TW         = (OPT_TIMEOUT > 1) ? $clog2(OPT_TIMEOUT) : 1;
    localparam bit            TIMEOUT_EN = (OPT_TIMEOUT > 0);
    localparam logic [TW-1:0] TIMER_LAST = TW'(OPT_TIMEOUT - 1);

    logic [CW-1:0]  count_reg, count_next;
    logic [NS-1:0]  grant_reg, grant_next;
    logic           err_pending_reg, err_pending_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic           ack_reg, ack_next;
    logic           err_reg, err_next;
    logic           timeout_reg;
    logic [RDW-1:0] rdata_reg, rdata_next;

    logic [NS-1:0]  slave_sel;
    logic           none_sel;
    logic           busy;
    logic           blocked;
    logic           req_stall;
    logic           acc;
    logic           acc_slave;
    logic           acc_none;
    logic           grant_ack;
    logic           grant_err;
    logic           resp;
    logic           fire;
    logic [RDW-1:0] rdata_mux;

    assign slave_sel = bus.decode[NS-1:0];
    assign none_sel  = bus.decode[NS];
    assign busy      = (count_reg != '0);

    // A new target may only be taken once every response from the old one is back.
    assign blocked = (busy && (slave_sel != grant_reg))
                   || (count_reg == COUNT_MAX)
                   || err_pending_reg
                   || (none_sel && busy);

    assign req_stall = bus.valid && (blocked || |(slave_sel & bus.sstall));
    assign acc       = bus.cyc && bus.valid && !req_stall;
    assign acc_slave = acc && |slave_sel;
    assign acc_none  = acc && none_sel;

    // Responses only count when they come from the granted slave with work outstanding.
    assign grant_ack = busy && |(bus.sack & grant_reg);
    assign grant_err = busy && |(bus.serr & grant_reg);
    assign resp      = grant_ack || grant_err;

    // A timeout is suppressed by any activity in the same cycle, which keeps ack and err exclusive.
    assign fire = TIMEOUT_EN && bus.cyc && busy && (timer_reg == TIMER_LAST) && !acc && !resp;

    for (genvar gi = 0; gi < NS; gi++) begin : g_route
        assign bus.svalid[gi] = bus.cyc && bus.valid && slave_sel[gi] && !blocked;
    end

    assign bus.stall   = req_stall;
    assign bus.saddr   = bus.addr;
    assign bus.sdata   = bus.data;
    assign bus.ack     = ack_reg;
    assign bus.err     = err_reg;
    assign bus.rdata   = rdata_reg;
    assign bus.timeout = timeout_reg;

    always_comb begin
        rdata_mux = '0;
        for (int k = 0; k < NS; k++) begin
            if (grant_reg[k]) begin
                rdata_mux = rdata_mux | bus.srdata[k*RDW +: RDW];
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (!bus.cyc || fire) begin
            count_next = '0;
        end else begin
            case ({acc_slave, resp})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_comb begin
        grant_next = grant_reg;
        if (!bus.cyc || fire) begin
            grant_next = '0;
        end else if (acc_slave) begin
            grant_next = slave_sel;
        end
    end

    always_comb begin
        timer_next = timer_reg + TW'(1);
        if (!TIMEOUT_EN || !bus.cyc || fire || acc || resp || !busy) begin
            timer_next = '0;
        end
    end

    assign err_pending_next = bus.cyc && acc_none;
    assign ack_next         = bus.cyc && grant_ack && !grant_err;
    assign err_next         = bus.cyc && (grant_err || err_pending_reg || fire);
    assign rdata_next       = ack_next ? rdata_mux : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg       <= '0;
            grant_reg       <= '0;
            err_pending_reg <= 1'b0;
            timer_reg       <= '0;
            ack_reg         <= 1'b0;
            err_reg         <= 1'b0;
            timeout_reg     <= 1'b0;
            rdata_reg       <= '0;
        end else begin
            count_reg       <= count_next;
            grant_reg       <= grant_next;
            err_pending_reg <= err_pending_next;
            timer_reg       <= timer_next;
            ack_reg         <= ack_next;
            err_reg         <= err_next;
            timeout_reg     <= fire;
            rdata_reg       <= rdata_next;
        end
    end
endmodule
